// File: rtl/csi2_frame_ctrl.sv
// CSI-2 frame capture controller: parses packet headers from the receiver word
// stream and sequences frame capture (arm, frame, stop) with a no-traffic abort.
module csi2_frame_ctrl #(
    parameter int VC      = 0,
    parameter int TIMEOUT = 1048576
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        capture_en_i,
    input  logic        pkt_tvalid_i,
    input  logic [31:0] pkt_tdata_i,
    input  logic        pkt_tlast_i,
    output logic        rx_enable_o,
    output logic        frame_active_o,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic [15:0] frame_num_o,
    output logic [15:0] line_cnt_o,
    output logic [15:0] last_lines_o,
    output logic        err_fs_o,
    output logic        err_timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_FRAME = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [1:0]  VC_ID  = 2'(VC);
    localparam logic [23:0] TO_LIM = 24'(TIMEOUT);

    state_t      state_q;
    state_t      state_d;
    logic        hdr_expect_q;
    logic        hdr_expect_d;
    logic [23:0] to_cnt_q;
    logic [23:0] to_cnt_d;

    logic        rx_enable_q;
    logic        frame_active_q;
    logic        frame_start_q;
    logic        frame_end_q;
    logic [15:0] frame_num_q;
    logic [15:0] line_cnt_q;
    logic [15:0] last_lines_q;
    logic        err_fs_q;
    logic        err_timeout_q;

    logic        is_hdr_s;
    logic        vc_match_s;
    logic [5:0]  dt_s;
    logic [15:0] wc_s;
    logic        is_fs_s;
    logic        is_fe_s;
    logic        is_line_s;
    logic        in_frame_s;
    logic        timeout_s;
    logic        unused_ecc_s;

    // Header field decode; ECC byte carried only to keep it visibly unused.
    always_comb begin
        dt_s         = pkt_tdata_i[5:0];
        wc_s         = pkt_tdata_i[23:8];
        unused_ecc_s = ^pkt_tdata_i[31:24];
        is_hdr_s     = pkt_tvalid_i & hdr_expect_q;
        vc_match_s   = (pkt_tdata_i[7:6] == VC_ID);
        is_fs_s      = is_hdr_s & vc_match_s & (dt_s == 6'h00);
        is_fe_s      = is_hdr_s & vc_match_s & (dt_s == 6'h01);
        is_line_s    = is_hdr_s & vc_match_s & (dt_s >= 6'h10);
        in_frame_s   = (state_q == ST_FRAME) || (state_q == ST_STOP);
        // Abort on the TIMEOUT-th consecutive cycle without a valid word.
        timeout_s    = in_frame_s & ~pkt_tvalid_i & (to_cnt_q == (TO_LIM - 24'd1));
    end

    // Header-expect flag and idle-cycle counter next state.
    always_comb begin
        hdr_expect_d = hdr_expect_q;
        to_cnt_d     = 24'd0;
        if (timeout_s) begin
            hdr_expect_d = 1'b1;
        end else if (pkt_tvalid_i && pkt_tlast_i) begin
            hdr_expect_d = 1'b1;
        end else if (is_hdr_s) begin
            hdr_expect_d = 1'b0;
        end else begin
            hdr_expect_d = hdr_expect_q;
        end

        if (in_frame_s && !pkt_tvalid_i && !timeout_s) begin
            to_cnt_d = to_cnt_q + 24'd1;
        end else begin
            to_cnt_d = 24'd0;
        end
    end

    // State transitions: timeout first, then header events, then capture_en_i.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (capture_en_i) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (is_fs_s) begin
                    state_d = ST_FRAME;
                end else if (!capture_en_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_FRAME: begin
                if (timeout_s) begin
                    state_d = ST_ARM;
                end else if (is_fe_s) begin
                    state_d = capture_en_i ? ST_ARM : ST_IDLE;
                end else if (is_fs_s) begin
                    state_d = ST_FRAME;
                end else if (!capture_en_i) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_FRAME;
                end
            end
            ST_STOP: begin
                if (timeout_s || is_fe_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame FSM with registered status outputs and event pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            hdr_expect_q   <= 1'b1;
            to_cnt_q       <= 24'd0;
            rx_enable_q    <= 1'b0;
            frame_active_q <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_end_q    <= 1'b0;
            frame_num_q    <= 16'd0;
            line_cnt_q     <= 16'd0;
            last_lines_q   <= 16'd0;
            err_fs_q       <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            hdr_expect_q   <= hdr_expect_d;
            to_cnt_q       <= to_cnt_d;
            rx_enable_q    <= (state_d != ST_IDLE);
            frame_active_q <= (state_d == ST_FRAME) || (state_d == ST_STOP);
            frame_start_q  <= 1'b0;
            frame_end_q    <= 1'b0;
            err_fs_q       <= 1'b0;
            err_timeout_q  <= 1'b0;

            case (state_q)
                ST_ARM: begin
                    if (is_fs_s) begin
                        frame_start_q <= 1'b1;
                        frame_num_q   <= wc_s;
                        line_cnt_q    <= 16'd0;
                    end
                end
                ST_FRAME, ST_STOP: begin
                    if (timeout_s) begin
                        err_timeout_q <= 1'b1;
                    end else if (is_fe_s) begin
                        frame_end_q  <= 1'b1;
                        last_lines_q <= line_cnt_q;
                    end else if (is_fs_s) begin
                        err_fs_q      <= 1'b1;
                        frame_start_q <= 1'b1;
                        frame_num_q   <= wc_s;
                        line_cnt_q    <= 16'd0;
                    end else if (is_line_s && (line_cnt_q != 16'hFFFF)) begin
                        line_cnt_q <= line_cnt_q + 16'd1;
                    end
                end
                default: begin
                    line_cnt_q <= line_cnt_q;
                end
            endcase
        end
    end

    assign rx_enable_o    = rx_enable_q;
    assign frame_active_o = frame_active_q;
    assign frame_start_o  = frame_start_q;
    assign frame_end_o    = frame_end_q;
    assign frame_num_o    = frame_num_q;
    assign line_cnt_o     = line_cnt_q;
    assign last_lines_o   = last_lines_q;
    assign err_fs_o       = err_fs_q;
    assign err_timeout_o  = err_timeout_q;

endmodule

// File: tb/tb_csi2_frame_ctrl.sv
// Scoreboard bench for csi2_frame_ctrl: directed packet sequences push expected
// pulse events; a negedge monitor pops and compares whenever a pulse appears.
module tb_csi2_frame_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        capture_en_i;
    logic        pkt_tvalid_i;
    logic [31:0] pkt_tdata_i;
    logic        pkt_tlast_i;
    logic        rx_enable_o;
    logic        frame_active_o;
    logic        frame_start_o;
    logic        frame_end_o;
    logic [15:0] frame_num_o;
    logic [15:0] line_cnt_o;
    logic [15:0] last_lines_o;
    logic        err_fs_o;
    logic        err_timeout_o;

    typedef struct packed {
        logic        fs;
        logic        fe;
        logic        efs;
        logic        eto;
        logic [15:0] num;
        logic [15:0] last;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk_i = ~clk_i;

    csi2_frame_ctrl #(.VC(1), .TIMEOUT(16)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .capture_en_i   (capture_en_i),
        .pkt_tvalid_i   (pkt_tvalid_i),
        .pkt_tdata_i    (pkt_tdata_i),
        .pkt_tlast_i    (pkt_tlast_i),
        .rx_enable_o    (rx_enable_o),
        .frame_active_o (frame_active_o),
        .frame_start_o  (frame_start_o),
        .frame_end_o    (frame_end_o),
        .frame_num_o    (frame_num_o),
        .line_cnt_o     (line_cnt_o),
        .last_lines_o   (last_lines_o),
        .err_fs_o       (err_fs_o),
        .err_timeout_o  (err_timeout_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc);
        return {8'h00, wc, vc, dt};
    endfunction

    task automatic push(input logic fs, input logic fe, input logic efs, input logic eto,
                        input logic [15:0] num, input logic [15:0] last);
        ev_t e;
        e = {fs, fe, efs, eto, num, last};
        exp_q.push_back(e);
    endtask

    task automatic word(input logic [31:0] d, input logic l);
        @(negedge clk_i);
        pkt_tvalid_i = 1'b1;
        pkt_tdata_i  = d;
        pkt_tlast_i  = l;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            pkt_tvalid_i = 1'b0;
            pkt_tlast_i  = 1'b0;
        end
    endtask

    // Payload words mimic FS/FE headers so a mis-parse would show up.
    task automatic long_pkt(input logic [1:0] vc);
        word(hdr(6'h2A, vc, 16'd12), 1'b0);
        word(32'h0000_0040, 1'b0);
        word(32'h0000_0041, 1'b0);
        word(32'hDEAD_BE50, 1'b1);
    endtask

    // Monitor: every pulse cycle must match the next expected event.
    always @(negedge clk_i) begin : mon
        ev_t got;
        ev_t ex;
        if (!rst_i && (frame_start_o || frame_end_o || err_fs_o || err_timeout_o)) begin
            got = {frame_start_o, frame_end_o, err_fs_o, err_timeout_o, frame_num_o, last_lines_o};
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {28'd0, got.fs, got.fe, got.efs, got.eto}, 32'd0);
            end else begin
                ex = exp_q.pop_front();
                check("pulse_flags", {28'd0, got.fs, got.fe, got.efs, got.eto},
                      {28'd0, ex.fs, ex.fe, ex.efs, ex.eto});
                check("pulse_frame_num", {16'd0, got.num}, {16'd0, ex.num});
                check("pulse_last_lines", {16'd0, got.last}, {16'd0, ex.last});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i        = 1'b1;
        capture_en_i = 1'b0;
        pkt_tvalid_i = 1'b0;
        pkt_tdata_i  = 32'd0;
        pkt_tlast_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_rx_enable", {31'd0, rx_enable_o}, 32'd0);
        check("rst_frame_active", {31'd0, frame_active_o}, 32'd0);
        check("rst_frame_num", {16'd0, frame_num_o}, 32'd0);
        check("rst_last_lines", {16'd0, last_lines_o}, 32'd0);
        rst_i        = 1'b0;
        capture_en_i = 1'b1;
        idle(2);
        check("arm_rx_enable", {31'd0, rx_enable_o}, 32'd1);
        check("arm_not_active", {31'd0, frame_active_o}, 32'd0);

        // Basic frame: FS(5), 3 lines, FE
        push(1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 16'd0);
        word(hdr(6'h00, 2'd1, 16'd5), 1'b1);
        repeat (3) long_pkt(2'd1);
        idle(1);
        check("f1_line_cnt", {16'd0, line_cnt_o}, 32'd3);
        check("f1_active", {31'd0, frame_active_o}, 32'd1);
        push(1'b0, 1'b1, 1'b0, 1'b0, 16'd5, 16'd3);
        word(hdr(6'h01, 2'd1, 16'd0), 1'b1);
        idle(1);
        check("f1_last_lines", {16'd0, last_lines_o}, 32'd3);
        check("f1_back_to_arm", {30'd0, rx_enable_o, frame_active_o}, 32'd2);

        // FS inside a frame restarts it
        push(1'b1, 1'b0, 1'b0, 1'b0, 16'd7, 16'd3);
        word(hdr(6'h00, 2'd1, 16'd7), 1'b1);
        long_pkt(2'd1);
        push(1'b1, 1'b0, 1'b1, 1'b0, 16'd9, 16'd3);
        word(hdr(6'h00, 2'd1, 16'd9), 1'b1);
        repeat (4) long_pkt(2'd1);
        push(1'b0, 1'b1, 1'b0, 1'b0, 16'd9, 16'd4);
        word(hdr(6'h01, 2'd1, 16'd0), 1'b1);
        idle(1);
        check("f2_last_lines", {16'd0, last_lines_o}, 32'd4);
        check("f2_frame_num", {16'd0, frame_num_o}, 32'd9);

        // Capture dropped mid-frame: STOP, then FE returns to IDLE
        push(1'b1, 1'b0, 1'b0, 1'b0, 16'd11, 16'd4);
        word(hdr(6'h00, 2'd1, 16'd11), 1'b1);
        idle(1);
        capture_en_i = 1'b0;
        idle(2);
        check("stop_active", {30'd0, rx_enable_o, frame_active_o}, 32'd3);
        repeat (2) long_pkt(2'd1);
        push(1'b0, 1'b1, 1'b0, 1'b0, 16'd11, 16'd2);
        word(hdr(6'h01, 2'd1, 16'd0), 1'b1);
        idle(1);
        check("stop_last_lines", {16'd0, last_lines_o}, 32'd2);
        idle(1);
        check("stop_to_idle", {30'd0, rx_enable_o, frame_active_o}, 32'd0);

        // Timeout after 16 idle cycles in FRAME
        capture_en_i = 1'b1;
        idle(2);
        push(1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 16'd2);
        push(1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 16'd2);
        word(hdr(6'h00, 2'd1, 16'd3), 1'b1);
        idle(16);
        check("to_not_yet", {31'd0, frame_active_o}, 32'd1);
        idle(1);
        check("to_aborted", {30'd0, rx_enable_o, frame_active_o}, 32'd2);
        check("to_last_lines", {16'd0, last_lines_o}, 32'd2);

        // Other-VC traffic is ignored, matching VC frames normally
        word(hdr(6'h00, 2'd0, 16'd20), 1'b1);
        repeat (2) long_pkt(2'd0);
        word(hdr(6'h01, 2'd0, 16'd0), 1'b1);
        idle(1);
        check("vc0_not_active", {31'd0, frame_active_o}, 32'd0);
        check("vc0_line_cnt", {16'd0, line_cnt_o}, 32'd0);
        check("vc0_frame_num", {16'd0, frame_num_o}, 32'd3);
        push(1'b1, 1'b0, 1'b0, 1'b0, 16'd20, 16'd2);
        word(hdr(6'h00, 2'd1, 16'd20), 1'b1);
        repeat (2) long_pkt(2'd1);
        long_pkt(2'd0);
        long_pkt(2'd1);
        idle(1);
        check("vc1_line_cnt", {16'd0, line_cnt_o}, 32'd3);
        push(1'b0, 1'b1, 1'b0, 1'b0, 16'd20, 16'd3);
        word(hdr(6'h01, 2'd1, 16'd0), 1'b1);
        idle(1);
        check("vc1_last_lines", {16'd0, last_lines_o}, 32'd3);

        // Reset in the middle of a long packet
        push(1'b1, 1'b0, 1'b0, 1'b0, 16'd30, 16'd3);
        word(hdr(6'h00, 2'd1, 16'd30), 1'b1);
        word(hdr(6'h2A, 2'd1, 16'd12), 1'b0);
        word(32'h1234_5678, 1'b0);
        idle(1);
        rst_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
        check("mrst_status", {29'd0, rx_enable_o, frame_active_o, err_fs_o}, 32'd0);
        check("mrst_frame_num", {16'd0, frame_num_o}, 32'd0);
        check("mrst_line_cnt", {16'd0, line_cnt_o}, 32'd0);
        check("mrst_last_lines", {16'd0, last_lines_o}, 32'd0);
        idle(1);
        push(1'b1, 1'b0, 1'b0, 1'b0, 16'd31, 16'd0);
        word(hdr(6'h00, 2'd1, 16'd31), 1'b1);
        idle(1);
        check("post_rst_active", {31'd0, frame_active_o}, 32'd1);
        check("post_rst_frame_num", {16'd0, frame_num_o}, 32'd31);
        push(1'b0, 1'b1, 1'b0, 1'b0, 16'd31, 16'd0);
        word(hdr(6'h01, 2'd1, 16'd0), 1'b1);
        idle(3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
